// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives PLL areset, retries on lock timeout, and
// releases a chain of staged active-high resets once lock has settled.
module pll_lock_supervisor #(
  parameter int unsigned ARESET_CYCLES      = 16,
  parameter int unsigned RELOCK_TIMEOUT     = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned NUM_STAGES         = 3,
  parameter int unsigned STAGE_GAP          = 16,
  parameter int unsigned CNT_W              = 17
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_locked,
  output logic                  o_pll_areset,
  output logic [NUM_STAGES-1:0] o_rst,
  output logic                  o_ready,
  output logic [7:0]            o_lost_cnt,
  output logic [3:0]            o_retry_cnt
);

  localparam int unsigned LOST_W  = 8;
  localparam int unsigned RETRY_W = 4;

  localparam logic [CNT_W-1:0] ARESET_LAST  = CNT_W'(ARESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RELOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic                    meta_q, lk_q;
  logic                    areset_q, areset_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic [LOST_W-1:0]       lost_q, lost_d;
  logic [RETRY_W-1:0]      retry_q, retry_d;

  // Two-flop synchronizer for the asynchronous PLL locked flag
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      lk_q   <= 1'b0;
    end else begin
      meta_q <= i_locked;
      lk_q   <= meta_q;
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= PLL_RST;
      timer_q  <= '0;
      areset_q <= 1'b1;
      rst_q    <= '1;
      ready_q  <= 1'b0;
      lost_q   <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      areset_q <= areset_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      lost_q   <= lost_d;
      retry_q  <= retry_d;
    end
  end

  // Next-state, timer and next-output logic; stages release by shifting
  // zeros in from bit 0 so ordering is ascending by construction
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + CNT_W'(1);
    rst_d   = rst_q;
    lost_d  = lost_q;
    retry_d = retry_q;
    unique case (state_q)
      PLL_RST: begin
        if (timer_q == ARESET_LAST) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end
      end
      WAIT_LOCK: begin
        if (lk_q) begin
          state_d = STABLE;
          timer_d = '0;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          timer_d = '0;
          retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
        end
      end
      STABLE: begin
        if (!lk_q) begin
          state_d = WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == STABLE_LAST) begin
          state_d = RELEASE;
          timer_d = '0;
          rst_d   = rst_q << 1;
        end
      end
      RELEASE: begin
        if (!lk_q) begin
          state_d = PLL_RST;
          timer_d = '0;
          rst_d   = '1;
          lost_d  = (lost_q == '1) ? lost_q : lost_q + LOST_W'(1);
        end else if (rst_q == '0) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == GAP_LAST) begin
          timer_d = '0;
          rst_d   = rst_q << 1;
        end
      end
      RUN: begin
        timer_d = '0;
        if (!lk_q) begin
          state_d = PLL_RST;
          rst_d   = '1;
          lost_d  = (lost_q == '1) ? lost_q : lost_q + LOST_W'(1);
        end
      end
      default: begin
        state_d = PLL_RST;
        timer_d = '0;
        rst_d   = '1;
      end
    endcase
    areset_d = (state_d == PLL_RST);
    ready_d  = (state_d == RUN);
  end

  assign o_pll_areset = areset_q;
  assign o_rst        = rst_q;
  assign o_ready      = ready_q;
  assign o_lost_cnt   = lost_q;
  assign o_retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: stimulus pushes expected output-change events (cycle and
// full output vector); a monitor pops and compares on every output change.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       pll_areset;
  logic [2:0] rst;
  logic       ready;
  logic [7:0] lost_cnt;
  logic [3:0] retry_cnt;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .ARESET_CYCLES(4),
    .RELOCK_TIMEOUT(32),
    .LOCK_STABLE_CYCLES(8),
    .NUM_STAGES(3),
    .STAGE_GAP(2),
    .CNT_W(17)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_locked(locked),
    .o_pll_areset(pll_areset),
    .o_rst(rst),
    .o_ready(ready),
    .o_lost_cnt(lost_cnt),
    .o_retry_cnt(retry_cnt)
  );

  typedef struct {
    int          cyc;
    logic [16:0] vec;
  } ev_t;

  ev_t         sb_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [16:0] cur, prev;
  ev_t         mev;

  function automatic logic [16:0] mk(input logic ar, input logic [2:0] r,
                                     input logic rdy, input int lost, input int retry);
    return {ar, r, rdy, 8'(lost), 4'(retry)};
  endfunction

  task automatic push(input int c, input logic [16:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    sb_q.push_back(e);
  endtask

  // Full release sequence for a lock whose first sampling edge is l+1
  task automatic push_rel(input int l, input int lost, input int retry);
    push(l + 11, mk(1'b0, 3'b110, 1'b0, lost, retry));
    push(l + 13, mk(1'b0, 3'b100, 1'b0, lost, retry));
    push(l + 15, mk(1'b0, 3'b000, 1'b0, lost, retry));
    push(l + 16, mk(1'b0, 3'b000, 1'b1, lost, retry));
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_%s cyc=%0d pending=%0d required=0 next_cyc=%0d next_vec=%h",
               tag, cyc, sb_q.size(), sb_q[0].cyc, sb_q[0].vec);
      sb_q.delete();
    end
  endtask

  // Monitor: count edges, sample 1 time unit after each edge, compare changes
  always @(posedge clk) begin
    cyc++;
    #1;
    cur = {pll_areset, rst, ready, lost_cnt, retry_cnt};
    if (mon_en && cur !== prev) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d actual=%h required=no_change", cyc, cur);
      end else begin
        mev = sb_q.pop_front();
        if (mev.cyc != cyc || mev.vec !== cur) begin
          failures++;
          $display("FAIL event cyc=%0d actual=%h required=%h at_cyc=%0d",
                   cyc, cur, mev.vec, mev.cyc);
        end
      end
    end
    prev = cur;
  end

  initial begin
    int d, l2, u, r, w, q, k, kk;
    rst_n  = 1'b0;
    locked = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checks++;
    if ({pll_areset, rst, ready, lost_cnt, retry_cnt} !== mk(1'b1, 3'b111, 1'b0, 0, 0)) begin
      failures++;
      $display("FAIL reset_state actual=%h required=%h",
               {pll_areset, rst, ready, lost_cnt, retry_cnt}, mk(1'b1, 3'b111, 1'b0, 0, 0));
    end

    // Nominal start
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push(cyc + 4, mk(1'b0, 3'b111, 1'b0, 0, 0));
    goto(cyc + 10);
    locked = 1'b1;
    push_rel(cyc, 0, 0);
    wait_drain(100, "nominal");

    // Loss during RUN, then relock; then loss mid-RELEASE
    d = cyc;
    locked = 1'b0;
    push(d + 3, mk(1'b1, 3'b111, 1'b0, 1, 0));
    push(d + 7, mk(1'b0, 3'b111, 1'b0, 1, 0));
    l2 = d + 10;
    goto(l2);
    locked = 1'b1;
    push(l2 + 11, mk(1'b0, 3'b110, 1'b0, 1, 0));
    goto(l2 + 10);
    locked = 1'b0;
    push(l2 + 13, mk(1'b1, 3'b111, 1'b0, 2, 0));
    push(l2 + 17, mk(1'b0, 3'b111, 1'b0, 2, 0));

    // Unstable lock: 5 high, 1 low, then high
    u = l2 + 20;
    goto(u);
    locked = 1'b1;
    goto(u + 5);
    locked = 1'b0;
    goto(u + 6);
    locked = 1'b1;
    push_rel(u + 6, 2, 0);
    wait_drain(100, "loss_unstable");

    // Reset mid-RUN; lock held low afterwards to exercise timeouts
    r = cyc;
    rst_n  = 1'b0;
    locked = 1'b0;
    push(r + 1, mk(1'b1, 3'b111, 1'b0, 0, 0));
    push(r + 5, mk(1'b0, 3'b111, 1'b0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Lock timeout: 17 retries, counter saturates at 15
    w = r + 5;
    for (k = 1; k <= 17; k++) begin
      kk = (k > 15) ? 15 : k;
      push(w + 32 + 36 * (k - 1), mk(1'b1, 3'b111, 1'b0, 0, kk));
      push(w + 36 * k, mk(1'b0, 3'b111, 1'b0, 0, kk));
    end
    wait_drain(1000, "timeout");

    // Reset clears a saturated retry counter
    q = cyc;
    rst_n = 1'b0;
    push(q + 1, mk(1'b1, 3'b111, 1'b0, 0, 0));
    push(q + 5, mk(1'b0, 3'b111, 1'b0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_drain(50, "final_reset");
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
